// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters.
// Owns the 4:1 mux select and sequences each transaction with a bounded wait.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mem_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic       busy,
    output logic [3:0] done,
    output logic [3:0] err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [0:0] state;
    logic [1:0] ptr;
    logic [7:0] wait_cnt;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       timeout_hit;
    logic       finish;

    // Walk from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign busy        = (state == BUSY);
    assign mem_valid   = busy;
    assign timeout_hit = busy && !mem_ready && (wait_cnt == LAST_CNT);
    assign finish      = (busy && mem_ready) || timeout_hit;
    assign done        = (busy && mem_ready) ? grant : 4'b0000;
    assign err         = timeout_hit ? grant : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            sel      <= 2'd0;
            ptr      <= 2'd0;
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (|req) begin
                state    <= BUSY;
                grant    <= 4'b0001 << winner;
                sel      <= winner;
                wait_cnt <= 8'd0;
            end
        end else if (finish) begin
            // sel is left alone so the mux output stays put through the idle cycle.
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= sel + 2'd1;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver predicts each transaction's
// owner and outcome, a separate monitor checks the port against those predictions.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       mem_ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid;
    logic       busy;
    logic [3:0] done;
    logic [3:0] err;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mem_ready(mem_ready),
        .grant(grant),
        .sel(sel),
        .mem_valid(mem_valid),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        bit         is_err;
        int         ncyc;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   mptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping mod 4.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_txn(input logic [3:0] r, input int lat);
        int w;
        int n;
        @(posedge clk); #1;
        req = r;
        mem_ready = 1'($urandom % 2);
        if (r != 4'b0000) begin
            w = pick(r, mptr);
            n = (lat > TIMEOUT) ? TIMEOUT : lat;
            sb.push_back('{owner: 2'(w), is_err: (lat > TIMEOUT), ncyc: n});
            mptr = (w + 1) % 4;
            for (int c = 1; c <= n; c++) begin
                @(posedge clk); #1;
                req = 4'($urandom);
                mem_ready = (c == lat);
            end
        end
    endtask

    task automatic do_abort(input logic [3:0] r, input int cyc);
        int w;
        @(posedge clk); #1;
        req = r;
        mem_ready = 1'b0;
        w = pick(r, mptr);
        sb.push_back('{owner: 2'(w), is_err: 1'b0, ncyc: 0});
        for (int c = 1; c <= cyc; c++) begin
            @(posedge clk); #1;
            req = 4'($urandom);
            mem_ready = 1'b0;
            if (c == cyc) begin
                reset = 1'b1;
                sb.delete();
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        req = 4'b0000;
        mptr = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req = 4'b0000;
        mem_ready = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        mptr = 0;
    endtask

    // Monitor: idle cycles must be quiet, busy cycles must match the queue head.
    initial begin : monitor
        int         bcnt;
        logic [1:0] last_sel;
        txn_t       t;
        bcnt = 0;
        last_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bcnt = 0;
                last_sel = 2'd0;
            end else if (!busy) begin
                chk("idle_grant", 32'(grant), 32'd0);
                chk("idle_valid", 32'(mem_valid), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_err", 32'(err), 32'd0);
                chk("idle_sel", 32'(sel), 32'(last_sel));
                chk("missing_strobe", 32'(bcnt), 32'd0);
                bcnt = 0;
            end else if (sb.size() == 0) begin
                chk("busy_unexpected", 32'(busy), 32'd0);
            end else begin
                t = sb[0];
                bcnt++;
                chk("busy_grant", 32'(grant), 32'(4'b0001 << t.owner));
                chk("busy_sel", 32'(sel), 32'(t.owner));
                chk("busy_valid", 32'(mem_valid), 32'd1);
                if (done != 4'b0000 || err != 4'b0000) begin
                    chk("done", 32'(done), t.is_err ? 32'd0 : 32'(4'b0001 << t.owner));
                    chk("err", 32'(err), t.is_err ? 32'(4'b0001 << t.owner) : 32'd0);
                    chk("busy_cycles", 32'(bcnt), 32'(t.ncyc));
                    last_sel = t.owner;
                    void'(sb.pop_front());
                    bcnt = 0;
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] r;
        // Reset held two cycles, then five quiet idle cycles.
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) do_txn(4'b0000, 0);

        do_txn(4'b0100, 3);

        apply_reset();
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 1);

        apply_reset();
        do_txn(4'b0010, 1);
        do_txn(4'b0011, 1);

        do_txn(4'b1000, TIMEOUT + 1);
        do_txn(4'b1111, 1);
        do_txn(4'b1000, TIMEOUT);

        do_abort(4'b0010, 2);
        do_txn(4'b0011, 1);

        for (int i = 0; i < 250; i++) begin
            r = 4'($urandom);
            if (r != 4'b0000 && ($urandom % 10) == 0)
                do_abort(r, $urandom_range(1, TIMEOUT - 1));
            else
                do_txn(r, $urandom_range(1, TIMEOUT + 3));
        end

        @(posedge clk); #1;
        req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
